hwpe_multi_stream_ctrl_fsm: RTL

// - Top-level HWPE control FSM for N_SRC source streams and N_SNK sink streams.
// - Runs a multi-iteration job: launches all enabled streams plus the engine, counts engine outputs to a

---
 rtl/hwpe_multi_stream_ctrl_pkg.sv | 26 ++
 rtl/hwpe_multi_stream_ctrl_fsm.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/hwpe_multi_stream_ctrl_pkg.sv
// ============================================================================
// Module : hwpe_multi_stream_ctrl_pkg
// Brief  : State encoding and default sizing for the multi-stream HWPE control FSM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hwpe_multi_stream_ctrl_pkg;

  localparam int unsigned c_def_n_src  = 2;
  localparam int unsigned c_def_n_snk  = 1;
  localparam int unsigned c_def_cnt_w  = 16;
  localparam int unsigned c_def_iter_w = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT      = 3'd2,
    COMPUTE   = 3'd3,
    UPDATE    = 3'd4,
    TERMINATE = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/hwpe_multi_stream_ctrl_fsm.sv
// ============================================================================
// Module : hwpe_multi_stream_ctrl_fsm
// Brief  : Job-level control FSM that launches N_SRC/N_SNK streams plus the
//          engine per iteration and steps the uloop until it reports done.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hwpe_multi_stream_ctrl_fsm
  import hwpe_multi_stream_ctrl_pkg::*;
#(
  parameter int unsigned N_SRC  = c_def_n_src,
  parameter int unsigned N_SNK  = c_def_n_snk,
  parameter int unsigned CNT_W  = c_def_cnt_w,
  parameter int unsigned ITER_W = c_def_iter_w
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [N_SRC-1:0]  src_en_i,
  input  logic [N_SNK-1:0]  snk_en_i,
  input  logic [N_SRC-1:0]  src_ready_start_i,
  input  logic [N_SNK-1:0]  snk_ready_start_i,
  output logic [N_SRC-1:0]  src_req_start_o,
  output logic [N_SNK-1:0]  snk_req_start_o,
  input  logic [CNT_W-1:0]  cnt_limit_i,
  input  logic [CNT_W-1:0]  eng_cnt_i,
  input  logic              eng_ready_i,
  output logic              eng_start_o,
  output logic              eng_clear_o,
  output logic              eng_enable_o,
  input  logic              ucode_valid_i,
  input  logic              ucode_done_i,
  output logic              ucode_enable_o,
  output logic              ucode_clear_o,
  output logic              done_o,
  output logic              evt_o,
  output logic              busy_o,
  output logic [ITER_W-1:0] iter_cnt_o
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ITER_W-1:0]   r_iter_cnt;
  logic [ITER_W-1:0]   w_iter_cnt_nxt;
  logic                w_all_rdy;
  logic                w_zero_len;
  logic                w_launch;

  // Disabled streams never hold back a launch.
  assign w_all_rdy  = (&(src_ready_start_i | ~src_en_i)) & (&(snk_ready_start_i | ~snk_en_i));
  assign w_zero_len = (cnt_limit_i == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_iter_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_iter_cnt <= w_iter_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_iter_cnt_nxt = r_iter_cnt;
    w_launch       = 1'b0;
    eng_start_o    = 1'b0;
    eng_clear_o    = 1'b1;
    eng_enable_o   = 1'b1;
    ucode_enable_o = 1'b0;
    ucode_clear_o  = 1'b0;
    done_o         = 1'b0;

    case (r_state)
      IDLE: begin
        ucode_clear_o = 1'b1;
        if (start_i) begin
          w_state_nxt    = START;
          w_iter_cnt_nxt = '0;
        end
      end

      START, WAIT: begin
        eng_clear_o = 1'b0;
        if (!w_all_rdy) begin
          eng_enable_o = 1'b0;
          w_state_nxt  = WAIT;
        end else if (w_zero_len) begin
          w_state_nxt = UPDATE;
        end else begin
          w_launch    = 1'b1;
          eng_start_o = 1'b1;
          w_state_nxt = COMPUTE;
        end
      end

      COMPUTE: begin
        eng_clear_o = 1'b0;
        eng_start_o = eng_ready_i;
        if (eng_cnt_i == cnt_limit_i) begin
          w_state_nxt = UPDATE;
          if (!(&r_iter_cnt)) begin
            w_iter_cnt_nxt = r_iter_cnt + 1'b1;
          end
        end
      end

      UPDATE: begin
        if (!ucode_valid_i) begin
          ucode_enable_o = 1'b1;
        end else if (ucode_done_i) begin
          w_state_nxt = TERMINATE;
        end else if (!w_all_rdy) begin
          w_state_nxt = WAIT;
        end else if (!w_zero_len) begin
          w_launch    = 1'b1;
          eng_start_o = 1'b1;
          w_state_nxt = COMPUTE;
        end
      end

      TERMINATE: begin
        eng_enable_o = 1'b0;
        if (w_all_rdy) begin
          done_o      = 1'b1;
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Abort and clear override any pulse or transition decided above.
    if (abort_i && (r_state != IDLE)) begin
      w_launch       = 1'b0;
      eng_start_o    = 1'b0;
      ucode_enable_o = 1'b0;
      done_o         = 1'b0;
      w_state_nxt    = TERMINATE;
      w_iter_cnt_nxt = r_iter_cnt;
    end
    if (clear_i) begin
      w_launch       = 1'b0;
      eng_start_o    = 1'b0;
      ucode_enable_o = 1'b0;
      done_o         = 1'b0;
      w_state_nxt    = IDLE;
      w_iter_cnt_nxt = '0;
    end
  end

  assign src_req_start_o = w_launch ? src_en_i : '0;
  assign snk_req_start_o = w_launch ? snk_en_i : '0;
  assign evt_o           = done_o;
  assign busy_o          = (r_state != IDLE);
  assign iter_cnt_o      = r_iter_cnt;

endmodule

`default_nettype wire
